dmem_wait_responder: RTL and testbench
======================================

Name: dmem_wait_responder

Overview:
- Responder end of the CPU data-memory interface. Serves word loads and stores issued by the datapath's DMEM port.
- Adds a programmable wait-state latency and a one-cycle ready/error response, so the core can be exercised against slow memory.
- Sits between the datapath's DMEM request signals and an internal word array. Replaces the zero-wait DMEM in latency-tolerant builds.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored. Must be a power of 2.
- LATENCY, 2: wait cycles between accept and response. Legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- nrst  input  1  reset; synchronous, active-high (1 = reset).
- read  input  1  load request.
- write  input  1  store request.
- address  input  32  byte address of the request.
- write_data  input  32  store data.
- read_data  output  32  load data; valid only while ready=1.
- ready  output  1  one-cycle response strobe.
- error  output  1  qualifies ready; 1 = request rejected.
- busy  output  1  high when a request is pending, i.e. the block is not in IDLE.

Behaviour:
- Reset values: read_data=0, ready=0, error=0, busy=0, state=IDLE, wait counter=0. Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If read|write=1 in cycle T, the request is accepted. Latch address, write_data, op and the error check.
  - Counter is loaded with LATENCY. If LATENCY=0, go to RESP; otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP.
- RESP:
  - ready=1 for exactly one cycle, T+1+LATENCY.
  - A store commits to the array on this edge. Load data is driven on read_data in this cycle.
  - Next state is always IDLE.
- Request inputs are sampled only in IDLE. Requests presented in WAIT or RESP are ignored. Back-to-back throughput is one request per LATENCY+2 cycles.
- read_data returns to 0 whenever ready=0.
- Error conditions, all checked at accept:
  - address[1:0]!=0 (misaligned);
  - address outside BASE_ADDR..BASE_ADDR+DEPTH_WORDS*4-1;
  - read=1 and write=1 together.
- An errored request follows the same latency. At the response, ready=1, error=1, read_data=0, and memory is not modified.
- Word index = (address-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits. The range check happens before truncation, so no aliasing occurs.
- A load to a word stored earlier returns the committed value. There is no forwarding inside an in-flight store, because only one request is outstanding.
- Reset mid-operation (nrst=1 in WAIT or RESP): return to IDLE next edge. A pending store is discarded. No ready is issued for the aborted request.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- Defined:
  - Adds input byte_en[3:0]. In RESP, a store updates only the lanes with byte_en[i]=1 (lane i = bits 8i+7:8i). byte_en is latched at accept.
  - A store with byte_en=0 completes with ready=1, error=0 and no change to memory.
  - Loads ignore byte_en.
- Undefined: no byte_en port; stores always write all 32 bits.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - LAT_W=4 (counter width);
  - WORD_W=32;
  - error-check helper constants.
- Sub-module dmem_word_array: synchronous-write, combinational-read storage with DEPTH_WORDS entries. Instantiated once, with byte-lane write under the macro.
- Top level holds the FSM, latches, latency counter and range checker.

Test Plan:
- Reset check: hold nrst=1 for 3 cycles -> ready=0, error=0, busy=0, read_data=0.
- Store then load, LATENCY=2:
  - write=1, address=0x10, write_data=0xDEADBEEF in cycle 5 -> ready=1 in cycle 8 with error=0.
  - read=1, address=0x10 in cycle 9 -> ready=1 in cycle 12 with read_data=0xDEADBEEF.
- LATENCY=0: load from address 0x0 accepted in cycle T -> ready=1 in cycle T+1. Back-to-back requests are accepted every 2 cycles.
- Errors:
  - read at 0x13 -> ready=1, error=1, read_data=0 after LATENCY+1 cycles.
  - write at BASE_ADDR+DEPTH_WORDS*4 (0x400) -> error=1; a subsequent load of word 0 is unchanged.
  - read=1 with write=1 together -> error=1.
- Ignored request: present read at 0x20 while busy=1 -> no extra ready pulse; only the first request is answered.
- Reset mid-op: start write of 0x12345678 to 0x40, assert nrst in the WAIT cycle -> no ready; a later load of 0x40 returns the prior value.
- Byte lanes (with DMEM_BYTE_WRITE_EN): word=0xFFFFFFFF, store 0x000000AA with byte_en=4'b0001 -> load returns 0xFFFFFFAA.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LAT_W      = 4;
   localparam int WORD_W     = 32;
   localparam int WORD_BYTES = 4;
   localparam int BYTE_LANES = 4;

   // Low address bits that must be zero for a legal word access.
   localparam logic [1:0] ALIGN_OK = 2'b00;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != ALIGN_OK;
   endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word storage: synchronous write, combinational read, contents never reset.
// With DMEM_BYTE_WRITE_EN defined, stores are masked per byte lane.
import dmem_pkg::*;

module dmem_word_array #(
   parameter int DEPTH_WORDS = 256,
   localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  write_index,
   input  logic [WORD_W-1:0] write_data,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [BYTE_LANES-1:0] byte_en,
`endif
   input  logic [IDX_W-1:0]  read_index,
   output logic [WORD_W-1:0] read_data
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

`ifdef DMEM_BYTE_WRITE_EN
   // Commit only the enabled byte lanes of a store.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (we && byte_en[i]) begin
            mem[write_index][8*i +: 8] <= write_data[8*i +: 8];
         end
      end
   end
`else
   // Commit the whole word of a store.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[write_index] <= write_data;
      end
   end
`endif

   assign read_data = mem[read_index];

endmodule

// File: rtl/dmem_wait_responder.sv
// DMEM responder with programmable wait states and a one-cycle ready/error
// strobe. Optional macro DMEM_BYTE_WRITE_EN adds per-lane store enables.
import dmem_pkg::*;

module dmem_wait_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       address,
   input  logic [WORD_W-1:0] write_data,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [BYTE_LANES-1:0] byte_en,
`endif
   output logic [WORD_W-1:0] read_data,
   output logic              ready,
   output logic              error,
   output logic              busy
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * WORD_BYTES);

   state_t             state;
   logic [LAT_W-1:0]   count;
   logic [IDX_W-1:0]   lat_index;
   logic [WORD_W-1:0]  lat_wdata;
   logic               lat_read;
   logic               lat_write;
   logic               lat_err;
`ifdef DMEM_BYTE_WRITE_EN
   logic [BYTE_LANES-1:0] lat_be;
`endif

   logic [31:0]        offset;
   logic               req_err;
   logic [IDX_W-1:0]   req_index;
   logic [IDX_W-1:0]   rd_index;
   logic [WORD_W-1:0]  arr_rdata;
   logic               arr_we;

   // Offset subtraction wraps for addresses below BASE_ADDR, so a single
   // unsigned compare covers both ends of the window before truncation.
   always_comb begin
      offset    = address - BASE_ADDR;
      req_err   = is_misaligned(offset[1:0]) || (offset >= SPAN) || (read && write);
      req_index = offset[IDX_W+1:2];
      rd_index  = (state == IDLE) ? req_index : lat_index;
   end

   assign arr_we = (state == RESP) && lat_write && !lat_err && !nrst;
   assign busy   = (state != IDLE);

   dmem_word_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk        (clk),
      .we         (arr_we),
      .write_index(lat_index),
      .write_data (lat_wdata),
`ifdef DMEM_BYTE_WRITE_EN
      .byte_en    (lat_be),
`endif
      .read_index (rd_index),
      .read_data  (arr_rdata)
   );

   // Request FSM: accept in IDLE, count wait states, then one response cycle.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state     <= IDLE;
         count     <= '0;
         ready     <= 1'b0;
         error     <= 1'b0;
         read_data <= '0;
         lat_index <= '0;
         lat_wdata <= '0;
         lat_read  <= 1'b0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
         lat_be    <= '0;
`endif
      end else begin
         ready     <= 1'b0;
         error     <= 1'b0;
         read_data <= '0;
         case (state)
            IDLE: begin
               if (read || write) begin
                  lat_index <= req_index;
                  lat_wdata <= write_data;
                  lat_read  <= read;
                  lat_write <= write;
                  lat_err   <= req_err;
`ifdef DMEM_BYTE_WRITE_EN
                  lat_be    <= byte_en;
`endif
                  count     <= LAT_W'(LATENCY);
                  if (LATENCY == 0) begin
                     state     <= RESP;
                     ready     <= 1'b1;
                     error     <= req_err;
                     read_data <= (read && !req_err) ? arr_rdata : '0;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               count <= count - 1'b1;
               if (count == LAT_W'(1)) begin
                  state     <= RESP;
                  ready     <= 1'b1;
                  error     <= lat_err;
                  read_data <= (lat_read && !lat_err) ? arr_rdata : '0;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: one instance with LATENCY=2 and
// one with LATENCY=0. Byte-lane vectors run when DMEM_BYTE_WRITE_EN is defined.
module tb_dmem_wait_responder;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;

   logic        read2 = 1'b0, write2 = 1'b0;
   logic [31:0] addr2 = '0, wdata2 = '0, rdata2;
   logic        ready2, error2, busy2;

   logic        read0 = 1'b0, write0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
   logic        ready0, error0, busy0;

`ifdef DMEM_BYTE_WRITE_EN
   logic [3:0]  be2 = 4'hF;
   logic [3:0]  be0 = 4'hF;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .nrst(nrst), .read(read2), .write(write2),
      .address(addr2), .write_data(wdata2),
`ifdef DMEM_BYTE_WRITE_EN
      .byte_en(be2),
`endif
      .read_data(rdata2), .ready(ready2), .error(error2), .busy(busy2)
   );

   dmem_wait_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .nrst(nrst), .read(read0), .write(write0),
      .address(addr0), .write_data(wdata0),
`ifdef DMEM_BYTE_WRITE_EN
      .byte_en(be0),
`endif
      .read_data(rdata0), .ready(ready0), .error(error0), .busy(busy0)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic sampleOut(input int sel, output logic r, output logic e,
                            output logic b, output logic [31:0] d);
      if (sel == 0) begin
         r = ready0; e = error0; b = busy0; d = rdata0;
      end else begin
         r = ready2; e = error2; b = busy2; d = rdata2;
      end
   endtask

   // One-cycle request, then wait (bounded) for the response and check it
   // plus the idle cycle that must follow.
   task automatic applyStimulus(input int sel, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int exp_lat, input logic exp_err,
                                input logic [31:0] exp_data, input string tag);
      int n;
      logic r, e, b;
      logic [31:0] d;
      @(negedge clk);
      if (sel == 0) begin
         read0 = rd; write0 = wr; addr0 = addr; wdata0 = wdata;
      end else begin
         read2 = rd; write2 = wr; addr2 = addr; wdata2 = wdata;
      end
      @(negedge clk);
      read0 = 1'b0; write0 = 1'b0; read2 = 1'b0; write2 = 1'b0;
      n = 1;
      sampleOut(sel, r, e, b, d);
      while (!r && n < 20) begin
         @(negedge clk);
         n++;
         sampleOut(sel, r, e, b, d);
      end
      checkOutput({tag, ".latency"}, 32'(n), 32'(exp_lat + 1));
      checkOutput({tag, ".ready"}, 32'(r), 32'd1);
      checkOutput({tag, ".error"}, 32'(e), 32'(exp_err));
      checkOutput({tag, ".data"}, d, exp_data);
      @(negedge clk);
      sampleOut(sel, r, e, b, d);
      checkOutput({tag, ".ready_drop"}, 32'(r), 32'd0);
      checkOutput({tag, ".data_drop"}, d, 32'h0);
      checkOutput({tag, ".idle"}, 32'(b), 32'd0);
   endtask

   initial begin : main
      int pulses;
      logic [31:0] seen;

      // Reset held for three cycles.
      repeat (3) @(negedge clk);
      checkOutput("reset.ready", 32'(ready2), 32'd0);
      checkOutput("reset.error", 32'(error2), 32'd0);
      checkOutput("reset.busy", 32'(busy2), 32'd0);
      checkOutput("reset.data", rdata2, 32'h0);
      checkOutput("reset.busy0", 32'(busy0), 32'd0);
      nrst = 1'b0;

      // Store then load with two wait states.
      applyStimulus(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, "store10");
      applyStimulus(2, 1'b1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, "load10");

      // Error cases; memory must be untouched afterwards.
      applyStimulus(2, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 2, 1'b0, 32'h0, "store0");
      applyStimulus(2, 1'b1, 1'b0, 32'h13, 32'h0, 2, 1'b1, 32'h0, "misalign");
      applyStimulus(2, 1'b0, 1'b1, 32'h400, 32'h0, 2, 1'b1, 32'h0, "range");
      applyStimulus(2, 1'b1, 1'b0, 32'h0, 32'h0, 2, 1'b0, 32'hA5A5A5A5, "load0");
      applyStimulus(2, 1'b1, 1'b1, 32'h10, 32'h0BAD0BAD, 2, 1'b1, 32'h0, "rdwr");
      applyStimulus(2, 1'b1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, "load10b");

      // A request held into WAIT (and retargeted) is ignored.
      pulses = 0;
      seen = '0;
      @(negedge clk);
      read2 = 1'b1; addr2 = 32'h10;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) addr2 = 32'h20;
         if (k == 2) read2 = 1'b0;
         if (ready2) begin
            pulses++;
            seen = rdata2;
         end
      end
      checkOutput("ignored.pulses", 32'(pulses), 32'd1);
      checkOutput("ignored.data", seen, 32'hDEADBEEF);

      // Reset in the WAIT cycle discards the store and its response.
      applyStimulus(2, 1'b0, 1'b1, 32'h40, 32'h11111111, 2, 1'b0, 32'h0, "store40");
      @(negedge clk);
      write2 = 1'b1; addr2 = 32'h40; wdata2 = 32'h12345678;
      @(negedge clk);
      write2 = 1'b0;
      checkOutput("abort.busy_wait", 32'(busy2), 32'd1);
      nrst = 1'b1;
      @(negedge clk);
      nrst = 1'b0;
      checkOutput("abort.busy", 32'(busy2), 32'd0);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (ready2) pulses++;
      end
      checkOutput("abort.no_ready", 32'(pulses), 32'd0);
      applyStimulus(2, 1'b1, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h11111111, "load40");

      // Zero-latency instance: single response and back-to-back throughput.
      applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 0, 1'b0, 32'h0, "l0.store");
      applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, 32'hCAFEF00D, "l0.load");
      applyStimulus(0, 1'b1, 1'b0, 32'h3FE, 32'h0, 0, 1'b1, 32'h0, "l0.misalign");
      pulses = 0;
      seen = '0;
      @(negedge clk);
      read0 = 1'b1; addr0 = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (ready0) begin
            pulses++;
            seen = rdata0;
         end
      end
      read0 = 1'b0;
      checkOutput("l0.b2b_pulses", 32'(pulses), 32'd3);
      checkOutput("l0.b2b_data", seen, 32'hCAFEF00D);
      @(negedge clk);

`ifdef DMEM_BYTE_WRITE_EN
      // Byte-lane stores.
      be2 = 4'hF;
      applyStimulus(2, 1'b0, 1'b1, 32'h80, 32'hFFFFFFFF, 2, 1'b0, 32'h0, "be.fill");
      be2 = 4'b0001;
      applyStimulus(2, 1'b0, 1'b1, 32'h80, 32'h000000AA, 2, 1'b0, 32'h0, "be.lane0");
      be2 = 4'b0000;
      applyStimulus(2, 1'b0, 1'b1, 32'h80, 32'h12345678, 2, 1'b0, 32'h0, "be.none");
      be2 = 4'b0000;
      applyStimulus(2, 1'b1, 1'b0, 32'h80, 32'h0, 2, 1'b0, 32'hFFFFFFAA, "be.load");
      be2 = 4'hF;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case something upstream hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
